// File: rtl/alu_result_buffer.sv
// FWFT result buffer between the shift/ALU stage and its consumer; tags each
// entry with the op code and precomputed zero/negative flags.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_res,
  input  logic [1:0]               in_funct,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_res,
  output logic [1:0]               out_funct,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = WIDTH + 4;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_err_q, drop_err_d;
  logic          push, pop;
  logic [EW-1:0] wr_entry, rd_entry;

  // Handshake flags depend only on registered occupancy
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry layout: {zero, neg, funct, result}
  assign wr_entry = {(in_res == '0), in_res[WIDTH-1], in_funct, in_res};
  assign rd_entry = mem_q[rd_ptr_q];

  assign out_res   = rd_entry[WIDTH-1:0];
  assign out_funct = rd_entry[WIDTH+1:WIDTH];
  assign out_neg   = rd_entry[WIDTH+2];
  assign out_zero  = rd_entry[WIDTH+3];
  assign count     = count_q;
  assign drop_err  = drop_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A presented result that is not accepted is lost; remember it
    if (in_valid && !in_ready) drop_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage is not reset; pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DEPTH=4, WIDTH=32).
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [1:0]  in_funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [1:0]  out_funct;
  logic        out_zero;
  logic        out_neg;
  logic [2:0]  count;
  logic        drop_err;

  int errors = 0;
  int checks = 0;

  alu_result_buffer #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_funct(out_funct), .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_res = 32'hDEAD_BEEF; in_funct = 2'b11;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] r, input logic [1:0] f);
    in_valid = 1'b1; in_res = r; in_funct = f; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
    // Popping an empty buffer does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_single();
    push(32'h0000_0010, 2'b01);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_res !== 32'h0000_0010) begin errors++; $display("FAIL single_res got=%h exp=00000010", out_res); end
    checks++; if (out_funct !== 2'b01) begin errors++; $display("FAIL single_funct got=%b exp=01", out_funct); end
    checks++; if ({out_zero, out_neg} !== 2'b00) begin errors++; $display("FAIL single_flags got=%b exp=00", {out_zero, out_neg}); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    // Idle-bus data must not disturb state
    in_res = 32'h0; in_funct = 2'b10;
    tick();
    checks++; if (out_res !== 32'h0000_0010) begin errors++; $display("FAIL idle_res got=%h exp=00000010", out_res); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop count=%0d valid=%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_flags();
    push(32'h0000_0000, 2'b10);
    push(32'h8000_0000, 2'b11);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL flags_count2 got=%0d exp=2", count); end
    checks++; if ({out_zero, out_neg} !== 2'b10 || out_res !== 32'h0) begin errors++; $display("FAIL flags_head0 zn=%b res=%h exp=10/00000000", {out_zero, out_neg}, out_res); end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flags_count1 got=%0d exp=1", count); end
    checks++; if ({out_zero, out_neg} !== 2'b01 || out_res !== 32'h8000_0000 || out_funct !== 2'b11) begin
      errors++; $display("FAIL flags_head1 zn=%b res=%h f=%b exp=01/80000000/11", {out_zero, out_neg}, out_res, out_funct); end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flags_count0 got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'h2; exp_q[1] = 32'h3; exp_q[2] = 32'h4; exp_q[3] = 32'h66;
    for (int i = 1; i <= 4; i++) push(32'(i), 2'(i));
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state count=%0d rdy=%b exp=4/0", count, in_ready); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL full_no_drop got=%b exp=0", drop_err); end
    push(32'h55, 2'b00);
    checks++; if (drop_err !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL drop_set drop=%b count=%0d exp=1/4", drop_err, count); end
    checks++; if (out_res !== 32'h1) begin errors++; $display("FAIL drop_head got=%h exp=00000001", out_res); end
    // Full: simultaneous push/pop only pops
    in_valid = 1'b1; in_res = 32'h66; in_funct = 2'b10; out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd3 || drop_err !== 1'b1) begin errors++; $display("FAIL full_pp count=%0d drop=%b exp=3/1", count, drop_err); end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_res !== exp_q[i]) begin
        errors++; $display("FAIL drain_%0d valid=%b res=%h exp=1/%h", i, out_valid, out_res, exp_q[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || drop_err !== 1'b1) begin errors++; $display("FAIL drained count=%0d drop=%b exp=0/1", count, drop_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL b2b_drop_clear got=%b exp=0", drop_err); end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_res = 32'h100 + 32'(k); in_funct = 2'(k);
      tick();
      checks++; if (count !== 3'd1 || out_res !== 32'h100 + 32'(k) || out_funct !== 2'(k)) begin
        errors++; $display("FAIL stream_%0d count=%0d res=%h f=%b exp=1/%h/%b", k, count, out_res, out_funct, 32'h100 + 32'(k), 2'(k)); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || drop_err !== 1'b0) begin errors++; $display("FAIL stream_end count=%0d drop=%b exp=0/0", count, drop_err); end
  endtask

  task automatic test_reset_partial();
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 2'b00);
    push(32'hFF, 2'b00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3 || drop_err !== 1'b1) begin errors++; $display("FAIL pre_rst count=%0d drop=%b exp=3/1", count, drop_err); end
    // Reset wins over a concurrent push and pop
    rst = 1'b1; in_valid = 1'b1; in_res = 32'h77; out_ready = 1'b1;
    tick();
    idle();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_err !== 1'b0) begin
      errors++; $display("FAIL rst_partial count=%0d valid=%b rdy=%b drop=%b exp=0/0/1/0", count, out_valid, in_ready, drop_err); end
    push(32'h0000_0ABC, 2'b01);
    checks++; if (count !== 3'd1 || out_res !== 32'h0000_0ABC || out_funct !== 2'b01) begin
      errors++; $display("FAIL post_rst_head count=%0d res=%h f=%b exp=1/00000abc/01", count, out_res, out_funct); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_single();
    test_flags();
    test_full();
    test_back_to_back();
    test_reset_partial();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of result entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning result data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an ALU/shift result is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the buffer accepts the presented result this cycle.
REQ-007 The block SHALL have port in_res, input, WIDTH, meaning result word from the shift/ALU stage.
REQ-008 The block SHALL have port in_funct, input, 2, meaning operation tag travelling with the result.
REQ-009 The block SHALL have port out_valid, output, 1, meaning head entry is available.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the head entry this cycle.
REQ-011 The block SHALL have port out_res, output, WIDTH, meaning head result word.
REQ-012 The block SHALL have port out_funct, output, 2, meaning head operation tag.
REQ-013 The block SHALL have port out_zero, output, 1, meaning head result equals zero.
REQ-014 The block SHALL have port out_neg, output, 1, meaning head result bit WIDTH-1.
REQ-015 The block SHALL have port count, output, log2(DEPTH)+1, meaning current occupancy.
REQ-016 The block SHALL have port drop_err, output, 1, meaning sticky flag: a result was presented while not accepted.

Function
REQ-017 Push SHALL occur when in_valid and in_ready are both 1 at a clock edge; pop when out_valid and out_ready are both 1.
REQ-018 in_ready SHALL equal (count < DEPTH), combinationally from registered count only; a pop in the same cycle does not make a full buffer ready.
REQ-019 out_valid SHALL equal (count != 0); out_res/out_funct/out_zero/out_neg SHALL reflect the head entry whenever out_valid is 1 (first-word-fall-through).
REQ-020 Latency: a result pushed into an empty buffer at edge N SHALL appear with out_valid=1 after edge N (one cycle).
REQ-021 out_zero and out_neg SHALL be computed from in_res at push time and stored with the entry.
REQ-022 Entries SHALL leave in push order; write and read pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 Push-only SHALL increment count by 1; pop-only SHALL decrement by 1; count SHALL never exceed DEPTH nor go below 0.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 in_valid=1 with in_ready=0 SHALL set drop_err at that edge; the result is discarded; drop_err remains 1 until reset.
REQ-027 in_res/in_funct values when in_valid=0 SHALL not affect state.
REQ-028 Stored entry storage contents are not reset; only pointers, count and drop_err.

Reset
REQ-029 With rst=1 at an edge: count=0, pointers=0, drop_err=0, hence out_valid=0 and in_ready=1 after that edge.
REQ-030 rst SHALL take priority over simultaneous push/pop; in-flight entries are discarded, including reset asserted with buffer partly full.
REQ-031 While out_valid=0, out_res/out_funct/out_zero/out_neg are don't-care.

Verification
REQ-032 Reset then push 0x0000_0010 funct=2'b01 -> next cycle out_valid=1, out_res=0x0000_0010, out_funct=01, out_zero=0, out_neg=0, count=1.
REQ-033 Push 0x0000_0000 then 0x8000_0000 with out_ready=0 -> heads show zero=1/neg=0, then after pop zero=0/neg=1; count 2 -> 1 -> 0.
REQ-034 Push 4 entries (DEPTH=4) with out_ready=0 -> count=4, in_ready=0; 5th push with in_valid=1 -> drop_err=1, count stays 4, pop order unchanged.
REQ-035 Full buffer, out_ready=1 and in_valid=1 same cycle -> pop only, count=3, drop_err=1; next cycle push accepted, count=4.
REQ-036 Streaming 10 results with in_valid=1, out_ready=1 continuously -> one accepted per cycle after first, count held at 1, outputs in order across pointer wrap.
REQ-037 Buffer holding 3 entries, rst=1 for one cycle -> count=0, out_valid=0, in_ready=1, drop_err=0; next push appears as the sole head.
